freq_search: RTL and testbench
==============================

# freq_search

Hill-climbing frequency search engine sitting directly upstream of the SWIPT optimisation stage. Averages the rectified-power samples measured at the currently applied frequency, compares each average against the previous one, and issues step requests (`freq_rdy` + `freq_set_up_down`) to the optimisation stage. It tracks the best frequency and power seen, and flags `freq_optimum`/`power_optimum` once the search has converged.

## Interface
- `PWR_W`, 12: power sample width.
- `AVG_LOG2`, 4: log2 of samples averaged per measurement (16).
- `SETTLE_CYCLES`, 1000: clocks waited after a frequency change before sampling; also the WAIT_STEP timeout.
- `REV_LIMIT`, 4: direction reversals that declare convergence.
- `F_MIN`, 20'h0C350 / `F_MAX`, 20'h30D40: search bounds (Hz).
- `PWR_MIN`, 12'h200: minimum best power for `power_optimum`.
- `HYST`, 12'h004: reversal hysteresis (used only with `FREQ_SEARCH_HYST_EN`).
- `clk` in 1: system clock, rising edge.
- `nrst` in 1: asynchronous active-low reset.
- `swiptAlive` in 1: link active; low aborts and clears the search.
- `freq` in 20: currently applied frequency (Hz).
- `pwr_sample` in PWR_W: measured power sample.
- `pwr_valid` in 1: `pwr_sample` valid this cycle.
- `freq_rdy` out 1: one-cycle step request.
- `freq_set_up_down` out 1: step direction, 1 = up.
- `freq_optimum` out 1: search converged (held).
- `power_optimum` out 1: converged and `best_pwr >= PWR_MIN` (held).
- `best_freq` out 20: frequency of highest average seen.
- `best_pwr` out PWR_W: highest average seen.

## Operation
- States: IDLE, SETTLE, ACCUM, DECIDE, WAIT_STEP, DONE.
- IDLE: clear accumulator, reversal count, `have_prev`, `best_*`, flags; direction = up. Go to SETTLE when `swiptAlive`.
- SETTLE: count SETTLE_CYCLES clocks, latch `freq` into `f_meas`, then go to ACCUM.
- ACCUM: add each `pwr_valid` sample into an accumulator of PWR_W+AVG_LOG2 bits; after 2^AVG_LOG2 samples go to DECIDE. `pwr_valid` is ignored in every other state.
- DECIDE (1 cycle): `avg = acc >> AVG_LOG2`.
  - Drop: `have_prev` and `avg < prev_avg` → invert direction, reversal count +1.
  - Otherwise direction is kept; first measurement keeps up.
  - Bounds: up with `f_meas >= F_MAX`, or down with `f_meas <= F_MIN` → force inward direction and count a reversal (at most one count per DECIDE).
  - `avg > best_pwr` (strict) → `best_pwr <= avg`, `best_freq <= f_meas`; ties keep the older entry.
  - `prev_avg <= avg`, `have_prev <= 1`.
  - Count reaching REV_LIMIT → DONE. Otherwise pulse `freq_rdy` and go to WAIT_STEP.
- WAIT_STEP: `freq != f_meas`, or timeout after SETTLE_CYCLES clocks → SETTLE (settle counter restarts).
- DONE: `freq_optimum = 1`; `power_optimum = (best_pwr >= PWR_MIN)`; hold until `swiptAlive` falls.
- `swiptAlive` low in any state → IDLE on the next edge, overriding every other event, including a concurrent `pwr_valid` or DECIDE.

## Timing
- Reset values: `freq_rdy` 0, `freq_set_up_down` 1, `freq_optimum` 0, `power_optimum` 0, `best_freq` 0, `best_pwr` 0. All outputs are registered.
- `freq_rdy` is high for exactly one cycle, on the clock after DECIDE. `freq_set_up_down` is updated on the same edge and held until the next DECIDE.
- Per-step latency without timeout: SETTLE_CYCLES + sample arrival time + 1 (DECIDE) + WAIT_STEP duration.
- `freq_optimum` and `power_optimum` rise on the same edge, one clock after the final DECIDE.
- A reset asserted mid-search returns to IDLE immediately (asynchronous) with all outputs at their reset values.

## Configuration
- `FREQ_SEARCH_HYST_EN` defined: the drop test becomes `avg + HYST < prev_avg`, with the sum computed at PWR_W+1 bits and no wrap. This suppresses reversals caused by noise.
- `FREQ_SEARCH_HYST_EN` undefined: strict `avg < prev_avg`; the `HYST` parameter is unused.

## Test plan
Bench parameters: SETTLE_CYCLES=8, AVG_LOG2=2, REV_LIMIT=2. `freq` is stepped ±50 Hz by the bench 1 cycle after each `freq_rdy`.
- Averages 100, 200, 300 → three `freq_rdy` pulses, all with `freq_set_up_down=1`; `best_pwr=300`.
- Averages 300, 250, 400, 350 → direction flips down, then up, reaching REV_LIMIT. `freq_optimum=1`, `best_freq` = frequency of the 400 measurement; no fourth `freq_rdy`.
- `freq` held at 20'h30D40 going up → next DECIDE forces direction down and counts a reversal.
- `swiptAlive` dropped in ACCUM with `pwr_valid` high → IDLE next cycle, `best_pwr=0`, no `freq_rdy`.
- Converged with `best_pwr=12'h1FF` → `freq_optimum=1`, `power_optimum=0`. Repeat with 12'h200 → `power_optimum=1`.
- With `FREQ_SEARCH_HYST_EN`: averages 300 then 297 → no reversal. Without the macro, the same averages → reversal.

Source files
------------

// File: rtl/freq_search.sv
// Hill-climbing frequency search: averages power per frequency step and walks toward the peak.
// Optional macro FREQ_SEARCH_HYST_EN adds HYST of hysteresis to the power-drop test.
module freq_search #(
  parameter int              PWR_W         = 12,
  parameter int              AVG_LOG2      = 4,
  parameter int              SETTLE_CYCLES = 1000,
  parameter int              REV_LIMIT     = 4,
  parameter logic [19:0]     F_MIN         = 20'h0C350,
  parameter logic [19:0]     F_MAX         = 20'h30D40,
  parameter logic [PWR_W-1:0] PWR_MIN      = 12'h200,
  parameter logic [PWR_W-1:0] HYST         = 12'h004
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swiptAlive,
  input  logic [19:0]      freq,
  input  logic [PWR_W-1:0] pwr_sample,
  input  logic             pwr_valid,
  output logic             freq_rdy,
  output logic             freq_set_up_down,
  output logic             freq_optimum,
  output logic             power_optimum,
  output logic [19:0]      best_freq,
  output logic [PWR_W-1:0] best_pwr
);

  localparam int ACC_W = PWR_W + AVG_LOG2;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int REV_W = $clog2(REV_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [REV_W-1:0] REV_LIMIT_V = REV_W'(REV_LIMIT);

  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, DECIDE, WAIT_STEP, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [AVG_LOG2-1:0] r_nsamp;
  logic [ACC_W-1:0]   r_acc;
  logic [PWR_W-1:0]   r_prev_avg, r_best_pwr;
  logic [19:0]        r_f_meas, r_best_freq;
  logic [REV_W-1:0]   r_rev;
  logic               r_have_prev, r_dir, r_freq_rdy, r_freq_opt, r_power_opt;

  logic [PWR_W-1:0]   w_avg, w_best_nxt;
  logic               w_drop, w_dir_a, w_at_hi, w_at_lo, w_dir_nxt, w_rev_inc, w_done, w_better;
  logic [REV_W-1:0]   w_rev_nxt;

  function automatic logic drop_test(input logic [PWR_W-1:0] avg, input logic [PWR_W-1:0] prev);
`ifdef FREQ_SEARCH_HYST_EN
    // Widened by one bit so avg + HYST cannot wrap.
    return ({1'b0, avg} + {1'b0, HYST}) < {1'b0, prev};
`else
    return avg < prev;
`endif
  endfunction

`ifndef FREQ_SEARCH_HYST_EN
  logic w_unused_hyst;
  assign w_unused_hyst = ^HYST;
`endif

  always_comb begin
    w_avg      = r_acc[ACC_W-1:AVG_LOG2];
    w_drop     = r_have_prev && drop_test(w_avg, r_prev_avg);
    w_dir_a    = w_drop ? ~r_dir : r_dir;
    w_at_hi    = w_dir_a && (r_f_meas >= F_MAX);
    w_at_lo    = !w_dir_a && (r_f_meas <= F_MIN);
    // Bound hit overrides direction; a drop plus a bound hit still counts one reversal.
    w_dir_nxt  = w_at_hi ? 1'b0 : (w_at_lo ? 1'b1 : w_dir_a);
    w_rev_inc  = w_drop | w_at_hi | w_at_lo;
    w_rev_nxt  = r_rev + REV_W'(w_rev_inc);
    w_done     = (w_rev_nxt >= REV_LIMIT_V);
    w_better   = (w_avg > r_best_pwr);
    w_best_nxt = w_better ? w_avg : r_best_pwr;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (swiptAlive) w_state_nxt = SETTLE;
      SETTLE:    if (r_cnt == CNT_LAST) w_state_nxt = ACCUM;
      ACCUM:     if (pwr_valid && (r_nsamp == '1)) w_state_nxt = DECIDE;
      DECIDE:    w_state_nxt = w_done ? DONE : WAIT_STEP;
      WAIT_STEP: if ((freq != r_f_meas) || (r_cnt == CNT_LAST)) w_state_nxt = SETTLE;
      DONE:      w_state_nxt = DONE;
      default:   w_state_nxt = IDLE;
    endcase
    if (!swiptAlive) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0; r_nsamp <= '0; r_acc <= '0; r_prev_avg <= '0; r_best_pwr <= '0;
      r_f_meas <= '0; r_best_freq <= '0; r_rev <= '0; r_have_prev <= 1'b0;
      r_dir <= 1'b1; r_freq_rdy <= 1'b0; r_freq_opt <= 1'b0; r_power_opt <= 1'b0;
    end else if (!swiptAlive || (r_state == IDLE)) begin
      r_cnt <= '0; r_nsamp <= '0; r_acc <= '0; r_prev_avg <= '0; r_best_pwr <= '0;
      r_best_freq <= '0; r_rev <= '0; r_have_prev <= 1'b0;
      r_dir <= 1'b1; r_freq_rdy <= 1'b0; r_freq_opt <= 1'b0; r_power_opt <= 1'b0;
    end else begin
      r_freq_rdy <= 1'b0;
      case (r_state)
        SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_f_meas <= freq;
            r_acc    <= '0;
            r_nsamp  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ACCUM: begin
          if (pwr_valid) begin
            r_acc   <= r_acc + ACC_W'(pwr_sample);
            r_nsamp <= r_nsamp + AVG_LOG2'(1);
          end
        end
        DECIDE: begin
          r_dir       <= w_dir_nxt;
          r_rev       <= w_rev_nxt;
          r_prev_avg  <= w_avg;
          r_have_prev <= 1'b1;
          r_cnt       <= '0;
          if (w_better) begin
            r_best_pwr  <= w_avg;
            r_best_freq <= r_f_meas;
          end
          if (w_done) begin
            r_freq_opt  <= 1'b1;
            r_power_opt <= (w_best_nxt >= PWR_MIN);
          end else begin
            r_freq_rdy  <= 1'b1;
          end
        end
        WAIT_STEP: begin
          if ((freq != r_f_meas) || (r_cnt == CNT_LAST)) r_cnt <= '0;
          else                                           r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign freq_rdy         = r_freq_rdy;
  assign freq_set_up_down = r_dir;
  assign freq_optimum     = r_freq_opt;
  assign power_optimum    = r_power_opt;
  assign best_freq        = r_best_freq;
  assign best_pwr         = r_best_pwr;

endmodule

// File: tb/tb_freq_search.sv
// Directed, table-driven bench for freq_search with short settle and averaging windows.
module tb_freq_search;

  localparam logic [19:0] F0    = 20'd100000;
  localparam logic [19:0] FMAXV = 20'h30D40;

  logic        clk, nrst, swiptAlive, pwr_valid;
  logic [19:0] freq;
  logic [11:0] pwr_sample;
  logic        freq_rdy, freq_set_up_down, freq_optimum, power_optimum;
  logic [19:0] best_freq;
  logic [11:0] best_pwr;

  freq_search #(.SETTLE_CYCLES(8), .AVG_LOG2(2), .REV_LIMIT(2)) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .freq(freq),
    .pwr_sample(pwr_sample), .pwr_valid(pwr_valid),
    .freq_rdy(freq_rdy), .freq_set_up_down(freq_set_up_down),
    .freq_optimum(freq_optimum), .power_optimum(power_optimum),
    .best_freq(best_freq), .best_pwr(best_pwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][11:0] v;
    logic [19:0]      f0;
    bit               step;
    int               np;
    logic [2:0]       dirs;
    bit               done;
    bit               popt;
    logic [11:0]      bpwr;
    logic [19:0]      bfreq;
    bit               fdir;
  } sc_t;

  int               n_run, n_fail;
  int               rdy_cnt, k;
  bit               pend, pend_dir, step_en;
  logic [3:0][11:0] vals;
  logic [7:0]       rdy_dir;
  sc_t              tbl [6];

  function automatic sc_t mk(input logic [11:0] a, b, c, d, input logic [19:0] f0, input bit step,
                             input int np, input logic [2:0] dirs, input bit done, input bit popt,
                             input logic [11:0] bpwr, input logic [19:0] bfreq, input bit fdir);
    sc_t s;
    s.v = {d, c, b, a}; s.f0 = f0; s.step = step; s.np = np; s.dirs = dirs; s.done = done;
    s.popt = popt; s.bpwr = bpwr; s.bfreq = bfreq; s.fdir = fdir;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: record step requests, step freq one cycle after each, advance the power table.
  task automatic tick();
    @(posedge clk);
    #2;
    if (pend) begin
      pend = 1'b0;
      k++;
      if (step_en) freq = pend_dir ? freq + 20'd50 : freq - 20'd50;
    end
    if (freq_rdy) begin
      if (rdy_cnt < 8) rdy_dir[rdy_cnt] = freq_set_up_down;
      rdy_cnt++;
      pend     = 1'b1;
      pend_dir = freq_set_up_down;
    end
    pwr_sample = vals[(k > 3) ? 3 : k];
  endtask

  task automatic start(input sc_t s);
    nrst = 1'b0; swiptAlive = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    vals = s.v; step_en = s.step; freq = s.f0;
    k = 0; pend = 1'b0; rdy_cnt = 0; rdy_dir = '0;
    pwr_sample = vals[0];
    tick();
    swiptAlive = 1'b1;
  endtask

  task automatic wait_rdy(input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (rdy_cnt >= n) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  task automatic run_sc(input sc_t s, input int idx);
    bit ok;
    start(s);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (s.done ? freq_optimum : (rdy_cnt >= s.np)) begin ok = 1'b1; break; end
    end
    chk($sformatf("s%0d_reached", idx), ok, 1);
    if (s.done) begin
      chk($sformatf("s%0d_popt_same_edge", idx), power_optimum, s.popt);
      repeat (40) tick();
      chk($sformatf("s%0d_pulse_count", idx), rdy_cnt, s.np);
      chk($sformatf("s%0d_fopt_held", idx), freq_optimum, 1);
      chk($sformatf("s%0d_popt_held", idx), power_optimum, s.popt);
    end else begin
      chk($sformatf("s%0d_fopt", idx), freq_optimum, 0);
    end
    for (int j = 0; j < s.np; j++)
      chk($sformatf("s%0d_dir%0d", idx, j), rdy_dir[j], s.dirs[j]);
    chk($sformatf("s%0d_best_pwr", idx), best_pwr, s.bpwr);
    chk($sformatf("s%0d_best_freq", idx), best_freq, s.bfreq);
    chk($sformatf("s%0d_dir_final", idx), freq_set_up_down, s.fdir);
  endtask

  initial begin
    n_run = 0; n_fail = 0; rdy_cnt = 0; k = 0; pend = 1'b0; pend_dir = 1'b0; step_en = 1'b1;
    rdy_dir = '0; vals = '0;
    nrst = 1'b0; swiptAlive = 1'b0; pwr_valid = 1'b1; freq = F0; pwr_sample = '0;

    tbl[0] = mk(12'd100, 12'd200, 12'd300, 12'd300, F0, 1'b1, 3, 3'b111, 1'b0, 1'b0,
                12'd300, F0 + 20'd100, 1'b1);
    tbl[1] = mk(12'd300, 12'd250, 12'd400, 12'd350, F0, 1'b1, 3, 3'b001, 1'b1, 1'b0,
                12'd400, F0, 1'b1);
    tbl[2] = mk(12'd100, 12'd200, 12'd200, 12'd200, FMAXV, 1'b0, 2, 3'b000, 1'b0, 1'b0,
                12'd200, FMAXV, 1'b0);
    tbl[3] = mk(12'h1FF, 12'h100, 12'h0F0, 12'h0F0, F0, 1'b1, 2, 3'b001, 1'b1, 1'b0,
                12'h1FF, F0, 1'b1);
    tbl[4] = mk(12'h200, 12'h100, 12'h0F0, 12'h0F0, F0, 1'b1, 2, 3'b001, 1'b1, 1'b1,
                12'h200, F0, 1'b1);
`ifdef FREQ_SEARCH_HYST_EN
    tbl[5] = mk(12'd300, 12'd297, 12'd297, 12'd297, F0, 1'b1, 2, 3'b011, 1'b0, 1'b0,
                12'd300, F0, 1'b1);
`else
    tbl[5] = mk(12'd300, 12'd297, 12'd297, 12'd297, F0, 1'b1, 2, 3'b001, 1'b0, 1'b0,
                12'd300, F0, 1'b0);
`endif

    #12;
    chk("rst_freq_rdy", freq_rdy, 0);
    chk("rst_dir", freq_set_up_down, 1);
    chk("rst_fopt", freq_optimum, 0);
    chk("rst_popt", power_optimum, 0);
    chk("rst_best_freq", best_freq, 0);
    chk("rst_best_pwr", best_pwr, 0);

    for (int i = 0; i < 6; i++) run_sc(tbl[i], i);

    // Link drop in the middle of the second averaging window with samples still valid.
    start(mk(12'd300, 12'd300, 12'd300, 12'd300, F0, 1'b1, 1, 3'b001, 1'b0, 1'b0,
             12'd300, F0, 1'b1));
    wait_rdy(1, "drop_first_pulse");
    chk("drop_best_before", best_pwr, 300);
    repeat (12) tick();
    swiptAlive = 1'b0;
    tick();
    chk("drop_best_pwr", best_pwr, 0);
    chk("drop_best_freq", best_freq, 0);
    chk("drop_freq_rdy", freq_rdy, 0);
    chk("drop_dir", freq_set_up_down, 1);
    repeat (30) tick();
    chk("drop_no_pulse", rdy_cnt, 1);

    // Asynchronous reset between clock edges while a step request is high.
    start(tbl[0]);
    wait_rdy(2, "arst_pulses");
    #1 nrst = 1'b0;
    #1;
    chk("arst_freq_rdy", freq_rdy, 0);
    chk("arst_best_pwr", best_pwr, 0);
    chk("arst_best_freq", best_freq, 0);
    chk("arst_dir", freq_set_up_down, 1);
    nrst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
